// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: default widths, reset PC, bubble encoding, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package legv8_pkg;

    localparam int          PC_WIDTH_DEF    = 64;
    localparam int          INSTR_WIDTH_DEF = 32;
    localparam logic [63:0] RESET_PC_DEF    = 64'h0;
    localparam int          PC_STEP_DEF     = 4;

    // A bubble carries an all-zero word; opcode 0 is a live encoding, so consumers gate on valid.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Opcode field fed straight to the decoder.
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 21;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // What the IF/ID register does this cycle.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_op_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with incrementer and redirect/hold/increment next-PC mux.
// Latency: new PC visible one cycle after redirect/advance is sampled.
// Backpressure: holds its value whenever neither redirect nor advance is asserted.
module pc_reg
    import legv8_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF),
    parameter int                  PC_STEP  = PC_STEP_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                advance,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_nxt;

    // Redirect beats increment; wrap past the top of the address space is silent.
    always_comb begin
        pc_inc = pc + PC_WIDTH'(PC_STEP);
        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = target;
        end else if (advance) begin
            pc_nxt = pc_inc;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// LEGv8 instruction fetch plus IF/ID register with stall, branch redirect/flush and halt control.
// Latency: word at pc=A lands in IF/ID one cycle later; a taken branch inserts exactly one bubble.
// Backpressure: stall freezes pc and IF/ID; halt parks the front end until released.
module if_id_stage
    import legv8_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
    parameter int                  PC_STEP     = PC_STEP_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   IF_Flush,
    input  logic                   halt,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid,
    output logic [10:0]            opcode,
    output logic                   halted
);

    state_t   state;
    state_t   state_nxt;
    ifid_op_t ifid_op;
    logic     pc_advance;

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (branch_taken),
        .target   (branch_target),
        .advance  (pc_advance),
        .pc       (pc)
    );

    assign imem_addr = pc;
    assign opcode    = if_id_instr[OPC_HI:OPC_LO];
    assign halted    = (state == ST_HALT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle fetch action; a taken branch redirects the PC in every state.
    always_comb begin
        state_nxt  = state;
        ifid_op    = IFID_BUBBLE;
        pc_advance = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = halt ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_op = IFID_BUBBLE;
                end else if (IF_Flush) begin
                    ifid_op    = IFID_BUBBLE;
                    pc_advance = !stall;
                end else if (stall) begin
                    ifid_op = IFID_HOLD;
                end else if (halt) begin
                    // pc is not advanced so the word at pc is refetched on resume.
                    ifid_op   = IFID_BUBBLE;
                    state_nxt = ST_HALT;
                end else begin
                    ifid_op    = IFID_LOAD;
                    pc_advance = 1'b1;
                end
            end
            ST_HALT: begin
                state_nxt = halt ? ST_HALT : ST_RUN;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // IF/ID pipeline register: capture, squash to bubble, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_pc    <= '0;
            if_id_instr <= INSTR_WIDTH'(NOP_INSTR);
            if_id_valid <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_LOAD: begin
                    if_id_pc    <= pc;
                    if_id_instr <= imem_rdata;
                    if_id_valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    if_id_pc    <= '0;
                    if_id_instr <= INSTR_WIDTH'(NOP_INSTR);
                    if_id_valid <= 1'b0;
                end
                default: begin
                    if_id_pc    <= if_id_pc;
                    if_id_instr <= if_id_instr;
                    if_id_valid <= if_id_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed scenarios plus randomized traffic against a reference model.
// Latency: one checked sample per clock, 1 time unit after the rising edge.
// Backpressure: stall/halt/branch inputs driven by the bench between edges.
module tb_if_id_stage;

    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, IF_Flush, halt;
    logic [63:0] branch_target;

    logic [63:0] addr0, pc0, ipc0, addr1, pc1, ipc1;
    logic [31:0] rdata0, instr0, rdata1, instr1;
    logic        valid0, halted0, valid1, halted1;
    logic [10:0] opc0, opc1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model state, one slot per DUT instance (0 = reset PC 0, 1 = reset PC at top of memory).
    logic [63:0] m_pc[2];
    logic [63:0] m_ipc[2];
    logic [31:0] m_instr[2];
    logic        m_valid[2];
    int          m_st[2];      // 0 boot, 1 run, 2 halt
    logic [63:0] m_rst_pc[2];

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_f(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B02_0020;
        if (a == 64'h4) return 32'hF840_0041;
        return {a[15:0] ^ 16'h5A3C, a[17:2] ^ a[33:18]};
    endfunction

    assign rdata0 = mem_f(addr0);
    assign rdata1 = mem_f(addr1);

    if_id_stage dut0 (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr0), .imem_rdata(rdata0),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .IF_Flush(IF_Flush), .halt(halt), .pc(pc0), .if_id_pc(ipc0),
        .if_id_instr(instr0), .if_id_valid(valid0), .opcode(opc0), .halted(halted0)
    );

    if_id_stage #(.RESET_PC(TOP_PC)) dut1 (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr1), .imem_rdata(rdata1),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .IF_Flush(IF_Flush), .halt(halt), .pc(pc1), .if_id_pc(ipc1),
        .if_id_instr(instr1), .if_id_valid(valid1), .opcode(opc1), .halted(halted1)
    );

    // Apply one clock of the front-end rules to the model.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic bubble;
            bubble = 1'b0;
            if (!rst_n) begin
                m_pc[i] = m_rst_pc[i]; m_ipc[i] = 64'h0; m_instr[i] = 32'h0;
                m_valid[i] = 1'b0; m_st[i] = 0;
            end else if (m_st[i] != 1) begin
                if (branch_taken) m_pc[i] = branch_target;
                bubble  = 1'b1;
                m_st[i] = halt ? 2 : 1;
            end else if (branch_taken) begin
                m_pc[i] = branch_target; bubble = 1'b1;
            end else if (IF_Flush) begin
                bubble = 1'b1;
                if (!stall) m_pc[i] = m_pc[i] + 64'd4;
            end else if (stall) begin
                // everything holds
            end else if (halt) begin
                bubble = 1'b1; m_st[i] = 2;
            end else begin
                m_instr[i] = mem_f(m_pc[i]); m_ipc[i] = m_pc[i]; m_valid[i] = 1'b1;
                m_pc[i] = m_pc[i] + 64'd4;
            end
            if (bubble) begin
                m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_ipc[i] = 64'h0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        stall = 0; branch_taken = 0; IF_Flush = 0; halt = 0; branch_target = 64'h0;
    endtask

    task automatic test_reset();
        rst_n = 0; drive_idle();
        tick(); tick();
        chk_cnt++; if (pc0 !== 64'h0) $display("FAIL reset_pc got %h exp %h", pc0, 64'h0); else pass_cnt++;
        chk_cnt++; if (addr0 !== 64'h0) $display("FAIL reset_addr got %h exp %h", addr0, 64'h0); else pass_cnt++;
        chk_cnt++; if (ipc0 !== 64'h0) $display("FAIL reset_ifid_pc got %h exp %h", ipc0, 64'h0); else pass_cnt++;
        chk_cnt++; if (instr0 !== 32'h0) $display("FAIL reset_instr got %h exp %h", instr0, 32'h0); else pass_cnt++;
        chk_cnt++; if (valid0 !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid0); else pass_cnt++;
        chk_cnt++; if (halted0 !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted0); else pass_cnt++;
        chk_cnt++; if (pc1 !== TOP_PC) $display("FAIL reset_pc_top got %h exp %h", pc1, TOP_PC); else pass_cnt++;
    endtask

    task automatic test_boot_run();
        rst_n = 1;
        tick();
        chk_cnt++; if (valid0 !== 1'b0 || pc0 !== 64'h0) $display("FAIL boot_cycle got valid=%b pc=%h exp valid=0 pc=0", valid0, pc0); else pass_cnt++;
        tick();
        chk_cnt++; if (instr0 !== 32'h8B02_0020 || ipc0 !== 64'h0 || valid0 !== 1'b1)
            $display("FAIL first_fetch got instr=%h pc=%h v=%b exp 8b020020/0/1", instr0, ipc0, valid0); else pass_cnt++;
        chk_cnt++; if (opc0 !== 11'b10001011000) $display("FAIL first_opcode got %b exp 10001011000", opc0); else pass_cnt++;
        tick();
        chk_cnt++; if (instr0 !== 32'hF840_0041 || ipc0 !== 64'h4 || pc0 !== 64'h8)
            $display("FAIL second_fetch got instr=%h ipc=%h pc=%h exp f8400041/4/8", instr0, ipc0, pc0); else pass_cnt++;
    endtask

    task automatic test_stall();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++; if (pc0 !== 64'h8 || instr0 !== 32'hF840_0041 || ipc0 !== 64'h4 || valid0 !== 1'b1)
                $display("FAIL stall_hold[%0d] got pc=%h instr=%h ipc=%h v=%b exp 8/f8400041/4/1", k, pc0, instr0, ipc0, valid0); else pass_cnt++;
        end
        stall = 0;
        tick();
        chk_cnt++; if (ipc0 !== 64'h8 || instr0 !== mem_f(64'h8) || pc0 !== 64'hC)
            $display("FAIL stall_resume got ipc=%h instr=%h pc=%h exp 8/%h/c", ipc0, instr0, pc0, mem_f(64'h8)); else pass_cnt++;
        tick();
    endtask

    task automatic test_branch();
        chk_cnt++; if (pc0 !== 64'h10) $display("FAIL branch_pre_pc got %h exp 10", pc0); else pass_cnt++;
        branch_taken = 1; IF_Flush = 1; stall = 1; branch_target = 64'h40;
        tick();
        drive_idle();
        chk_cnt++; if (pc0 !== 64'h40 || valid0 !== 1'b0 || instr0 !== 32'h0)
            $display("FAIL branch_redirect got pc=%h v=%b instr=%h exp 40/0/0", pc0, valid0, instr0); else pass_cnt++;
        tick();
        chk_cnt++; if (ipc0 !== 64'h40 || valid0 !== 1'b1 || instr0 !== mem_f(64'h40))
            $display("FAIL branch_target_fetch got ipc=%h v=%b instr=%h exp 40/1/%h", ipc0, valid0, instr0, mem_f(64'h40)); else pass_cnt++;
    endtask

    task automatic test_flush();
        branch_taken = 1; IF_Flush = 1; branch_target = 64'h20;
        tick();
        drive_idle();
        IF_Flush = 1;
        tick();
        IF_Flush = 0;
        chk_cnt++; if (pc0 !== 64'h24 || valid0 !== 1'b0 || instr0 !== 32'h0)
            $display("FAIL flush_alone got pc=%h v=%b instr=%h exp 24/0/0", pc0, valid0, instr0); else pass_cnt++;
    endtask

    task automatic test_halt();
        branch_taken = 1; IF_Flush = 1; branch_target = 64'h30;
        tick();
        drive_idle();
        halt = 1;
        tick();
        chk_cnt++; if (halted0 !== 1'b1 || pc0 !== 64'h30 || valid0 !== 1'b0)
            $display("FAIL halt_enter got halted=%b pc=%h v=%b exp 1/30/0", halted0, pc0, valid0); else pass_cnt++;
        tick();
        chk_cnt++; if (halted0 !== 1'b1 || pc0 !== 64'h30) $display("FAIL halt_stay got halted=%b pc=%h exp 1/30", halted0, pc0); else pass_cnt++;
        halt = 0;
        tick();
        chk_cnt++; if (halted0 !== 1'b0 || pc0 !== 64'h30 || valid0 !== 1'b0)
            $display("FAIL halt_release got halted=%b pc=%h v=%b exp 0/30/0", halted0, pc0, valid0); else pass_cnt++;
        tick();
        chk_cnt++; if (ipc0 !== 64'h30 || valid0 !== 1'b1 || instr0 !== mem_f(64'h30) || pc0 !== 64'h34)
            $display("FAIL halt_refetch got ipc=%h v=%b instr=%h pc=%h exp 30/1/%h/34", ipc0, valid0, instr0, pc0, mem_f(64'h30)); else pass_cnt++;
    endtask

    task automatic test_wrap();
        stall = 1;
        tick();
        rst_n = 0;
        tick();
        chk_cnt++; if (pc1 !== TOP_PC || ipc1 !== 64'h0 || instr1 !== 32'h0 || valid1 !== 1'b0 || halted1 !== 1'b0)
            $display("FAIL reset_mid_stall got pc=%h ipc=%h instr=%h v=%b h=%b exp %h/0/0/0/0", pc1, ipc1, instr1, valid1, halted1, TOP_PC); else pass_cnt++;
        chk_cnt++; if (pc0 !== 64'h0 || valid0 !== 1'b0) $display("FAIL reset_mid_stall0 got pc=%h v=%b exp 0/0", pc0, valid0); else pass_cnt++;
        rst_n = 1; stall = 0;
        tick();
        tick();
        chk_cnt++; if (ipc1 !== TOP_PC || instr1 !== mem_f(TOP_PC) || pc1 !== 64'h0)
            $display("FAIL wrap_top got ipc=%h instr=%h pc=%h exp %h/%h/0", ipc1, instr1, pc1, TOP_PC, mem_f(TOP_PC)); else pass_cnt++;
        tick();
        chk_cnt++; if (ipc1 !== 64'h0 || instr1 !== 32'h8B02_0020 || pc1 !== 64'h4)
            $display("FAIL wrap_zero got ipc=%h instr=%h pc=%h exp 0/8b020020/4", ipc1, instr1, pc1); else pass_cnt++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            rst_n         = ($urandom_range(0, 59) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) branch_target = branch_target & ~64'h3;
            IF_Flush      = branch_taken | ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) halt = ~halt;
            tick();
            for (int i = 0; i < 2; i++) begin
                logic [63:0] g_pc, g_addr, g_ipc;
                logic [31:0] g_instr;
                logic        g_v, g_h;
                logic [10:0] g_op;
                logic [31:0] e_instr;
                e_instr = m_instr[i];
                if (i == 0) begin g_pc = pc0; g_addr = addr0; g_ipc = ipc0; g_instr = instr0; g_v = valid0; g_h = halted0; g_op = opc0; end
                else        begin g_pc = pc1; g_addr = addr1; g_ipc = ipc1; g_instr = instr1; g_v = valid1; g_h = halted1; g_op = opc1; end
                chk_cnt++;
                if ({g_pc, g_addr, g_ipc, g_instr, g_v, g_h, g_op} !==
                    {m_pc[i], m_pc[i], m_ipc[i], e_instr, m_valid[i], (m_st[i] == 2), e_instr[31:21]}) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random[%0d] dut%0d got pc=%h addr=%h ipc=%h instr=%h v=%b h=%b op=%h exp pc=%h ipc=%h instr=%h v=%b h=%b",
                                 n, i, g_pc, g_addr, g_ipc, g_instr, g_v, g_h, g_op,
                                 m_pc[i], m_ipc[i], e_instr, m_valid[i], (m_st[i] == 2));
                end else begin
                    pass_cnt++;
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        m_rst_pc[0] = 64'h0;
        m_rst_pc[1] = TOP_PC;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 64'h0; m_ipc[i] = 64'h0; m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_st[i] = 0;
        end
        rst_n = 0;
        drive_idle();
        test_reset();
        test_boot_run();
        test_stall();
        test_branch();
        test_flush();
        test_halt();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
